// File: rtl/des_ctrl_pkg.sv
// des_ctrl_pkg: shared types and constants for the DES block sequencer.
//   state_e        - sequencer states (IDLE, ISSUE, WAIT, OUT)
//   MODE_ECB/CBC   - values of the latched chaining-mode bit
//   BLK_W          - DES block width in bits
//   chain_mask()   - the word XORed into the cleartext for the active mode
package des_ctrl_pkg;

    localparam int BLK_W = 64;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

    // ECB adds nothing to the cleartext; CBC folds in the previous ciphertext (or IV)
    function automatic logic [BLK_W-1:0] chain_mask(input logic mode, input logic [BLK_W-1:0] chain);
        logic [BLK_W-1:0] mask;
        if (mode == MODE_CBC) begin
            mask = chain;
        end else begin
            mask = {BLK_W{1'b0}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/des_ctrl_timeout.sv
// des_ctrl_timeout: watchdog counter for the core-wait phase.
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   clear  - restart the count from zero
//   run    - advance the count this cycle (waiting, no result yet)
//   expire - run is high on the last allowed cycle (count == TIMEOUT_CYCLES-1)
module des_ctrl_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter; wraps to zero on expiry so a stale value never lingers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (run) begin
            if (count_r == LAST) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = run && (count_r == LAST);

endmodule

// File: rtl/des_blk_ctrl.sv
// des_blk_ctrl: one-block-in-flight sequencer in front of a single-block DES core.
//   i_cfg_*        - key / IV / mode configuration, taken on i_cfg_load in IDLE only
//   o_cfg_nack     - pulse: a config strobe arrived while busy and was dropped
//   i_data/i_valid/o_ready  - input block stream
//   o_data/o_valid/i_ready  - result stream
//   o_des_*/i_des_*         - core interface (cleartext, key, dv strobe, ciphertext, dv)
//   o_busy         - sequencer not in IDLE
//   o_timeout      - sticky: a block was abandoned because the core never answered
//   o_blk_count    - results delivered, wrapping
module des_blk_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BLK_W-1:0]  i_cfg_key,
    input  logic [BLK_W-1:0]  i_cfg_iv,
    input  logic              i_cfg_mode,
    input  logic              i_cfg_load,
    output logic              o_cfg_nack,
    input  logic [BLK_W-1:0]  i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [BLK_W-1:0]  o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BLK_W-1:0]  o_des_cleartext,
    output logic [BLK_W-1:0]  o_des_key,
    output logic              o_des_dv,
    input  logic [BLK_W-1:0]  i_des_ciphertext,
    input  logic              i_des_dv,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_blk_count
);

    state_e state_r;
    state_e state_nx_s;

    logic [BLK_W-1:0] key_r;
    logic [BLK_W-1:0] chain_r;
    logic             mode_r;
    logic [BLK_W-1:0] cleartext_r;
    logic [BLK_W-1:0] data_r;
    logic             valid_r;
    logic             des_dv_r;
    logic             cfg_nack_r;
    logic             timeout_r;
    logic [CNT_W-1:0] blk_count_r;

    logic ready_s;
    logic cfg_take_s;
    logic accept_s;
    logic done_s;
    logic deliver_s;
    logic tmo_clear_s;
    logic tmo_run_s;
    logic expire_s;

    des_ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  (tmo_clear_s),
        .run    (tmo_run_s),
        .expire (expire_s)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-state control strobes; config beats data in IDLE
    always_comb begin
        state_nx_s  = state_r;
        ready_s     = 1'b0;
        cfg_take_s  = 1'b0;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        deliver_s   = 1'b0;
        tmo_clear_s = 1'b0;
        tmo_run_s   = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = !i_cfg_load;
                if (i_cfg_load) begin
                    cfg_take_s = 1'b1;
                end else if (i_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                tmo_clear_s = 1'b1;
                state_nx_s  = WAIT;
            end
            WAIT: begin
                if (i_des_dv) begin
                    done_s     = 1'b1;
                    state_nx_s = OUT;
                end else begin
                    tmo_run_s = 1'b1;
                    if (expire_s) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end
            end
            OUT: begin
                if (i_ready) begin
                    deliver_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = OUT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Configuration and chaining registers; chain follows ciphertext only in CBC
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            key_r   <= {BLK_W{1'b0}};
            mode_r  <= MODE_ECB;
            chain_r <= {BLK_W{1'b0}};
        end else if (cfg_take_s) begin
            key_r   <= i_cfg_key;
            mode_r  <= i_cfg_mode;
            chain_r <= i_cfg_iv;
        end else if (done_s && (mode_r == MODE_CBC)) begin
            key_r   <= key_r;
            mode_r  <= mode_r;
            chain_r <= i_des_ciphertext;
        end else begin
            key_r   <= key_r;
            mode_r  <= mode_r;
            chain_r <= chain_r;
        end
    end

    // Core-side drive: cleartext captured on accept, dv strobe is the ISSUE cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cleartext_r <= {BLK_W{1'b0}};
            des_dv_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                cleartext_r <= i_data ^ chain_mask(mode_r, chain_r);
            end else begin
                cleartext_r <= cleartext_r;
            end
            des_dv_r <= accept_s;
        end
    end

    // Result stream, delivery counter and status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_r      <= {BLK_W{1'b0}};
            valid_r     <= 1'b0;
            blk_count_r <= {CNT_W{1'b0}};
            cfg_nack_r  <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            if (done_s) begin
                data_r  <= i_des_ciphertext;
                valid_r <= 1'b1;
            end else if (deliver_s) begin
                data_r  <= data_r;
                valid_r <= 1'b0;
            end else begin
                data_r  <= data_r;
                valid_r <= valid_r;
            end

            if (deliver_s) begin
                blk_count_r <= blk_count_r + CNT_W'(1);
            end else begin
                blk_count_r <= blk_count_r;
            end

            cfg_nack_r <= i_cfg_load && (state_r != IDLE);

            if (cfg_take_s) begin
                timeout_r <= 1'b0;
            end else if (tmo_run_s && expire_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign o_ready         = ready_s;
    assign o_data          = data_r;
    assign o_valid         = valid_r;
    assign o_des_cleartext = cleartext_r;
    assign o_des_key       = key_r;
    assign o_des_dv        = des_dv_r;
    assign o_cfg_nack      = cfg_nack_r;
    assign o_timeout       = timeout_r;
    assign o_blk_count     = blk_count_r;
    assign o_busy          = (state_r != IDLE);

endmodule

// File: tb/tb_des_blk_ctrl.sv
// Self-checking bench for des_blk_ctrl with a behavioural core stub (latency 2).
module tb_des_blk_ctrl;

    localparam int TMO = 64;
    localparam int LAT = 2;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] KEY_C = 64'hFFEEDDCCBBAA9988;
    localparam logic [63:0] PT_KA = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_KA = 64'h85E813540F0AB405;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [63:0] i_cfg_key = 64'h0;
    logic [63:0] i_cfg_iv = 64'h0;
    logic        i_cfg_mode = 1'b0;
    logic        i_cfg_load = 1'b0;
    logic        o_cfg_nack;
    logic [63:0] i_data = 64'h0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [63:0] o_des_cleartext;
    logic [63:0] o_des_key;
    logic        o_des_dv;
    logic [63:0] i_des_ciphertext;
    logic        i_des_dv;
    logic        o_busy;
    logic        o_timeout;
    logic [15:0] o_blk_count;

    des_blk_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cfg_key(i_cfg_key), .i_cfg_iv(i_cfg_iv), .i_cfg_mode(i_cfg_mode),
        .i_cfg_load(i_cfg_load), .o_cfg_nack(o_cfg_nack),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_des_cleartext(o_des_cleartext), .o_des_key(o_des_key), .o_des_dv(o_des_dv),
        .i_des_ciphertext(i_des_ciphertext), .i_des_dv(i_des_dv),
        .o_busy(o_busy), .o_timeout(o_timeout), .o_blk_count(o_blk_count)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- core stub ----------------
    logic        hang = 1'b0;
    logic        inj = 1'b0;
    logic [63:0] inj_data = 64'h0;
    logic [1:0]  dv_pipe = 2'b00;
    logic [63:0] ct_p0 = 64'h0;
    logic [63:0] ct_p1 = 64'h0;

    // Known-answer pair for KEY_A, otherwise a simple keyed XOR
    function automatic logic [63:0] core_f(input logic [63:0] pt, input logic [63:0] key);
        if (key == KEY_A && pt == PT_KA) return CT_KA;
        else return pt ^ key ^ 64'hA5A5A5A5A5A5A5A5;
    endfunction

    always @(posedge i_clk) begin
        dv_pipe <= {dv_pipe[0], o_des_dv};
        ct_p0   <= core_f(o_des_cleartext, o_des_key);
        ct_p1   <= ct_p0;
    end

    assign i_des_dv         = inj | (dv_pipe[1] & ~hang);
    assign i_des_ciphertext = inj ? inj_data : ct_p1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_count = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_cfg(input logic [63:0] key, input logic [63:0] iv, input logic mode);
        i_cfg_key  = key;
        i_cfg_iv   = iv;
        i_cfg_mode = mode;
        i_cfg_load = 1'b1;
        @(negedge i_clk);
        i_cfg_load = 1'b0;
    endtask

    // Present one block; returns in the cycle after the accept edge
    task automatic accept_block(input logic [63:0] din);
        int w;
        w = 0;
        #1;
        while (!o_ready && w < 50) begin
            @(negedge i_clk);
            #1;
            w++;
        end
        chk("ready_wait", 64'(w < 50), 64'd1);
        i_valid = 1'b1;
        i_data  = din;
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
    endtask

    task automatic send_block(input logic [63:0] din, input logic [63:0] exp_ct,
                              input logic [63:0] exp_out, input int hold);
        int dv_seen;
        int lat;
        accept_block(din);
        chk("des_dv_issue", 64'(o_des_dv), 64'd1);
        chk("cleartext", o_des_cleartext, exp_ct);
        dv_seen = 1;
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(negedge i_clk);
            #1;
            lat++;
            if (o_des_dv) dv_seen++;
        end
        chk("des_dv_once", 64'(dv_seen), 64'd1);
        chk("latency", 64'(lat), 64'(LAT + 1));
        chk("o_data", o_data, exp_out);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            i_data  = ~din;
            #1;
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_data", o_data, exp_out);
            chk("bp_no_issue", 64'(o_des_dv), 64'd0);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        #1;
        chk("valid_drop", 64'(o_valid), 64'd0);
        chk("blk_count", 64'(o_blk_count), 64'(exp_count));
    endtask

    typedef struct {
        logic        cfg;
        logic [63:0] key;
        logic [63:0] iv;
        logic        mode;
        logic [63:0] din;
        logic [63:0] exp_ct;
        logic [63:0] exp_out;
        int          hold;
    } vec_t;

    vec_t vt[6];

    initial begin
        int busy_cycles;
        logic saw_valid;

        vt[0] = '{1'b1, KEY_A, 64'h0, 1'b0, PT_KA, PT_KA, CT_KA, 0};
        vt[1] = '{1'b0, KEY_A, 64'h0, 1'b0, 64'h0, 64'h0, 64'hB691F2DC3E197A54, 0};
        vt[2] = '{1'b1, KEY_A, PT_KA, 1'b1, 64'h0, PT_KA, CT_KA, 0};
        vt[3] = '{1'b0, KEY_A, PT_KA, 1'b1, 64'h84CB563386A179EA, PT_KA, CT_KA, 0};
        vt[4] = '{1'b0, KEY_A, PT_KA, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h7A17ECABF0F54BFA, 64'hCC861E77CEEC31AE, 0};
        vt[5] = '{1'b1, KEY_A, 64'h0, 1'b0, PT_KA, PT_KA, CT_KA, 10};

        // Reset state
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_data", o_data, 64'h0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_des_dv", 64'(o_des_dv), 64'd0);
        chk("rst_nack", 64'(o_cfg_nack), 64'd0);
        chk("rst_timeout", 64'(o_timeout), 64'd0);
        chk("rst_count", 64'(o_blk_count), 64'd0);
        chk("rst_cleartext", o_des_cleartext, 64'h0);
        chk("rst_key", o_des_key, 64'h0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);

        // Table: ECB KAT, CBC chaining, backpressure
        for (int i = 0; i < 6; i++) begin
            if (vt[i].cfg) load_cfg(vt[i].key, vt[i].iv, vt[i].mode);
            send_block(vt[i].din, vt[i].exp_ct, vt[i].exp_out, vt[i].hold);
        end

        // Config collides with data in IDLE: config wins, block taken next cycle
        @(negedge i_clk);
        i_cfg_key  = KEY_B;
        i_cfg_iv   = 64'h0;
        i_cfg_mode = 1'b0;
        i_cfg_load = 1'b1;
        i_valid    = 1'b1;
        i_data     = 64'h1111111111111111;
        #1;
        chk("coll_ready", 64'(o_ready), 64'd0);
        @(negedge i_clk);
        i_cfg_load = 1'b0;
        #1;
        chk("coll_not_taken", 64'(o_busy), 64'd0);
        chk("coll_key", o_des_key, KEY_B);
        chk("coll_ready_next", 64'(o_ready), 64'd1);
        hang = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        chk("coll_issue", 64'(o_des_dv), 64'd1);
        chk("coll_cleartext", o_des_cleartext, 64'h1111111111111111);
        @(negedge i_clk);
        i_cfg_key  = KEY_C;
        i_cfg_load = 1'b1;
        @(negedge i_clk);
        i_cfg_load = 1'b0;
        #1;
        chk("nack_pulse", 64'(o_cfg_nack), 64'd1);
        chk("nack_key_kept", o_des_key, KEY_B);
        @(negedge i_clk);
        #1;
        chk("nack_one_cycle", 64'(o_cfg_nack), 64'd0);
        inj_data = 64'hDEADBEEFCAFEF00D;
        inj = 1'b1;
        @(negedge i_clk);
        inj = 1'b0;
        #1;
        chk("inj_valid", 64'(o_valid), 64'd1);
        chk("inj_data", o_data, 64'hDEADBEEFCAFEF00D);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        #1;
        chk("inj_count", 64'(o_blk_count), 64'(exp_count));

        // Timeout: core never answers
        accept_block(64'h2222222222222222);
        busy_cycles = 1;
        saw_valid = 1'b0;
        while (o_busy && busy_cycles < 300) begin
            if (o_valid) saw_valid = 1'b1;
            @(negedge i_clk);
            #1;
            busy_cycles++;
        end
        chk("tmo_duration", 64'(busy_cycles), 64'(TMO + 2));
        chk("tmo_flag", 64'(o_timeout), 64'd1);
        chk("tmo_no_valid", 64'(saw_valid | o_valid), 64'd0);
        inj_data = 64'h5555555555555555;
        inj = 1'b1;
        @(negedge i_clk);
        inj = 1'b0;
        #1;
        chk("late_dv_valid", 64'(o_valid), 64'd0);
        chk("late_dv_busy", 64'(o_busy), 64'd0);
        chk("late_dv_data", o_data, 64'hDEADBEEFCAFEF00D);
        chk("tmo_count", 64'(o_blk_count), 64'(exp_count));
        load_cfg(KEY_A, 64'h0, 1'b0);
        #1;
        chk("tmo_cleared", 64'(o_timeout), 64'd0);

        // Reset mid-WAIT, then a stale core strobe
        accept_block(64'h3333333333333333);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_count = 16'h0;
        #1;
        chk("mrst_busy", 64'(o_busy), 64'd0);
        chk("mrst_data", o_data, 64'h0);
        chk("mrst_cleartext", o_des_cleartext, 64'h0);
        chk("mrst_key", o_des_key, 64'h0);
        chk("mrst_count", 64'(o_blk_count), 64'd0);
        inj = 1'b1;
        @(negedge i_clk);
        inj = 1'b0;
        #1;
        chk("mrst_stale_valid", 64'(o_valid), 64'd0);
        chk("mrst_stale_busy", 64'(o_busy), 64'd0);
        hang = 1'b0;

        // Counter wrap from near full
        load_cfg(KEY_A, 64'h0, 1'b0);
        force dut.blk_count_r = 16'hFFFE;
        release dut.blk_count_r;
        exp_count = 16'hFFFE;
        send_block(PT_KA, PT_KA, CT_KA, 0);
        send_block(PT_KA, PT_KA, CT_KA, 0);
        chk("wrap_zero", 64'(o_blk_count), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
